dma_mem_responder: RTL



---
 rtl/dma_resp_pkg.sv | 22 ++
 rtl/dma_mem_responder_if.sv | 23 ++
 rtl/dma_resp_ram.sv | 25 ++
 rtl/dma_mem_responder.sv | 129 ++++++++++++
 4 files changed

// File: rtl/dma_resp_pkg.sv
// Shared types and constants for the DMA memory responder: FSM states,
// byte-write-enable encodings and the counter saturation helper.
package dma_resp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [1:0] WE_RD   = 2'b00;
  localparam logic [1:0] WE_LO   = 2'b01;
  localparam logic [1:0] WE_HI   = 2'b10;
  localparam logic [1:0] WE_WORD = 2'b11;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == CNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/dma_mem_responder_if.sv
// 16-bit DMA word bus between an initiator (master) and a responder (slave).
interface dma_mem_responder_if #(
  parameter int ADD_LEN = 15
);
  logic [ADD_LEN:1] dma_addr;
  logic [15:0]      dma_din;
  logic             dma_en;
  logic [1:0]       dma_we;
  logic             dma_priority;
  logic [15:0]      dma_dout;
  logic             dma_ready;
  logic             dma_resp;

  modport master (
    output dma_addr, dma_din, dma_en, dma_we, dma_priority,
    input  dma_dout, dma_ready, dma_resp
  );

  modport slave (
    input  dma_addr, dma_din, dma_en, dma_we, dma_priority,
    output dma_dout, dma_ready, dma_resp
  );
endinterface

// File: rtl/dma_resp_ram.sv
// Single-port word RAM with per-byte write enables; read data registered,
// read-before-write on the same access.
module dma_resp_ram
  import dma_resp_pkg::*;
#(
  parameter int MEM_WORDS = 256,
  parameter int AW        = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [1:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata
);
  logic [15:0] mem_q [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (|(we & WE_LO)) mem_q[addr][7:0]  <= wdata[7:0];
      if (|(we & WE_HI)) mem_q[addr][15:8] <= wdata[15:8];
      rdata <= mem_q[addr];
    end
  end
endmodule

// File: rtl/dma_mem_responder.sv
// DMA responder backing a word window with byte-writable RAM and wait states.
// Define DMA_RESP_ERR_EN to report out-of-window accesses as errors.
module dma_mem_responder
  import dma_resp_pkg::*;
#(
  parameter int          ADD_LEN     = 15,
  parameter int          DATA_LEN    = 16,
  parameter int          MEM_WORDS   = 256,
  parameter int unsigned BASE_ADDR   = 'h0100,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  dma_mem_responder_if.slave bus,
  output logic [15:0]        rd_cnt,
  output logic [15:0]        wr_cnt,
  output logic [15:0]        err_cnt
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [ADD_LEN-1:0] BASE = ADD_LEN'(BASE_ADDR);

  state_e              state_q;
  logic [3:0]          wait_q;
  logic [ADD_LEN-1:0]  addr_q;
  logic [DATA_LEN-1:0] din_q;
  logic [1:0]          we_q;
  logic                ready_q, rd_ok_q;
  logic [15:0]         rd_cnt_q, wr_cnt_q;

  logic                take, go_resp, in_win;
  logic [3:0]          load_cnt;
  logic [ADD_LEN-1:0]  cur_addr;
  logic [DATA_LEN-1:0] cur_din;
  logic [1:0]          cur_we, ram_we;
  logic [AW-1:0]       ram_addr;
  logic [15:0]         ram_rdata;

  // A zero-wait access must hit the RAM on its accept edge, so the live bus
  // feeds the RAM while accepting and the latched request feeds it otherwise.
  assign take     = (state_q != ST_WAIT) && bus.dma_en;
  assign load_cnt = bus.dma_priority ? 4'd0 : 4'(WAIT_STATES);
  assign cur_addr = take ? bus.dma_addr : addr_q;
  assign cur_din  = take ? bus.dma_din  : din_q;
  assign cur_we   = take ? bus.dma_we   : we_q;
  assign go_resp  = take ? (load_cnt == 4'd0)
                         : ((state_q == ST_WAIT) && (wait_q == 4'd1));
  assign ram_addr = AW'(cur_addr - BASE);
  assign ram_we   = (go_resp && in_win) ? cur_we : WE_RD;

`ifdef DMA_RESP_ERR_EN
  assign in_win = (cur_addr >= BASE) && ((cur_addr - BASE) < ADD_LEN'(MEM_WORDS));
`else
  assign in_win = 1'b1;
`endif

  dma_resp_ram #(.MEM_WORDS(MEM_WORDS), .AW(AW)) u_ram (
    .clk   (clk),
    .en    (go_resp),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (cur_din),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      wait_q   <= '0;
      addr_q   <= '0;
      din_q    <= '0;
      we_q     <= WE_RD;
      ready_q  <= 1'b0;
      rd_ok_q  <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      ready_q <= go_resp;
      rd_ok_q <= go_resp && in_win && (cur_we == WE_RD);
      if (go_resp && in_win) begin
        if (cur_we == WE_RD) rd_cnt_q <= sat_inc(rd_cnt_q);
        else                 wr_cnt_q <= sat_inc(wr_cnt_q);
      end
      case (state_q)
        ST_WAIT: begin
          wait_q <= wait_q - 4'd1;
          if (wait_q == 4'd1) state_q <= ST_RESP;
        end
        default: begin
          if (bus.dma_en) begin
            addr_q  <= bus.dma_addr;
            din_q   <= bus.dma_din;
            we_q    <= bus.dma_we;
            wait_q  <= load_cnt;
            state_q <= (load_cnt == 4'd0) ? ST_RESP : ST_WAIT;
          end else begin
            state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

`ifdef DMA_RESP_ERR_EN
  logic        resp_q;
  logic [15:0] err_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_q    <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      resp_q <= go_resp && !in_win;
      if (go_resp && !in_win) err_cnt_q <= sat_inc(err_cnt_q);
    end
  end

  assign bus.dma_resp = resp_q;
  assign err_cnt      = err_cnt_q;
`else
  assign bus.dma_resp = 1'b0;
  assign err_cnt      = '0;
`endif

  // Read data is only presented for okay reads; writes and errors return 0.
  assign bus.dma_dout  = rd_ok_q ? ram_rdata : 16'h0000;
  assign bus.dma_ready = ready_q;
  assign rd_cnt        = rd_cnt_q;
  assign wr_cnt        = wr_cnt_q;
endmodule
